// File: rtl/fetch_decode.sv
// rtl/fetch_decode.sv - instruction fetch and IF/ID decode with two-word jump collection
module fetch_decode #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr_o,
  input  logic [15:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i,
  output logic [1:0]  format_o,
  output logic [3:0]  opcode_o,
  output logic [2:0]  reg1_o,
  output logic [2:0]  reg2_o,
  output logic [2:0]  regD_o,
  output logic [2:0]  imm_o,
  output logic        immFlag_o,
  output logic [15:0] jmpLoc_o,
  output logic        valid_o
);

  typedef enum logic {DECODE, EXT} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] pc;
  logic        rd_valid;
  logic        advance;
  logic        is_jump;

  assign advance = rd_valid & ~stall_i & ~redirect_i;
  assign is_jump = (imem_rdata_i[15:14] == 2'b11);

  // Next pc is always the address presented, so a stall simply re-reads pc.
  always_comb begin
    imem_addr_o = pc;
    if (redirect_i) begin
      imem_addr_o = redirect_pc_i;
    end else if (advance) begin
      imem_addr_o = pc + 16'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (redirect_i) begin
      state_nxt = DECODE;
    end else if (advance) begin
      if (state == DECODE) begin
        state_nxt = is_jump ? EXT : DECODE;
      end else begin
        state_nxt = DECODE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DECODE;
      pc       <= RESET_PC;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= imem_addr_o;
      rd_valid <= 1'b1;
    end
  end

  // On redirect the fields keep their old values; only valid_o drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      format_o  <= 2'd0;
      opcode_o  <= 4'd0;
      reg1_o    <= 3'd0;
      reg2_o    <= 3'd0;
      regD_o    <= 3'd0;
      imm_o     <= 3'd0;
      immFlag_o <= 1'b0;
      jmpLoc_o  <= 16'd0;
      valid_o   <= 1'b0;
    end else if (redirect_i) begin
      valid_o <= 1'b0;
    end else if (advance) begin
      if (state == DECODE) begin
        format_o  <= imem_rdata_i[15:14];
        opcode_o  <= imem_rdata_i[13:10];
        immFlag_o <= imem_rdata_i[9];
        regD_o    <= imem_rdata_i[8:6];
        reg1_o    <= imem_rdata_i[5:3];
        reg2_o    <= imem_rdata_i[9] ? 3'd0 : imem_rdata_i[2:0];
        imm_o     <= imem_rdata_i[9] ? imem_rdata_i[2:0] : 3'd0;
        jmpLoc_o  <= 16'd0;
        valid_o   <= ~is_jump;
      end else begin
        jmpLoc_o <= imem_rdata_i;
        valid_o  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// tb/tb_fetch_decode.sv - self-checking bench for fetch_decode with instruction-stream scoreboard
module tb_fetch_decode;

  localparam logic [15:0] RPC = 16'h0010;

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [1:0]  format_o;
  logic [3:0]  opcode_o;
  logic [2:0]  reg1_o, reg2_o, regD_o, imm_o;
  logic        immFlag_o;
  logic [15:0] jmpLoc_o;
  logic        valid_o;

  logic [15:0] mem [0:65535];
  logic [35:0] exp_q [$];
  logic [35:0] last_out;
  logic [35:0] cur;
  logic [35:0] e;
  logic        edge_stall, edge_redirect, chk_en;
  logic [15:0] held_addr;
  int          n_pass, n_total;
  bit          found;

  fetch_decode #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .format_o(format_o), .opcode_o(opcode_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .regD_o(regD_o),
    .imm_o(imm_o), .immFlag_o(immFlag_o), .jmpLoc_o(jmpLoc_o), .valid_o(valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  always @(posedge clk) begin
    edge_stall    = stall;
    edge_redirect = redirect;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Expected output record of one instruction, derived from the word layout.
  function automatic logic [35:0] model_instr(input logic [15:0] w, input logic [15:0] ext);
    int unsigned v, f, op, fl, rd, r1, lo, r2, im, jl;
    v  = w;
    f  = v / 16384;
    op = (v / 1024) % 16;
    fl = (v / 512) % 2;
    rd = (v / 64) % 8;
    r1 = (v / 8) % 8;
    lo = v % 8;
    r2 = fl ? 0 : lo;
    im = fl ? lo : 0;
    jl = (f == 3) ? ext : 0;
    return {1'b1, f[1:0], op[3:0], fl[0], rd[2:0], r1[2:0], r2[2:0], im[2:0], jl[15:0]};
  endfunction

  task automatic build(input logic [15:0] start);
    logic [15:0] a, a1, w;
    a = start;
    exp_q.delete();
    for (int i = 0; i < 48; i++) begin
      w  = mem[a];
      a1 = a + 16'd1;
      if (w[15:14] == 2'b11) begin
        exp_q.push_back(model_instr(w, mem[a1]));
        a = a + 16'd2;
      end else begin
        exp_q.push_back(model_instr(w, 16'h0000));
        a = a1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cur = {valid_o, format_o, opcode_o, immFlag_o, regD_o, reg1_o, reg2_o, imm_o, jmpLoc_o};
      if (edge_redirect) begin
        check("redirect_flush_valid", {63'd0, valid_o}, 64'd0);
      end else if (edge_stall) begin
        check("stall_hold", {28'd0, cur}, {28'd0, last_out});
      end else if (valid_o) begin
        if (exp_q.size() == 0) begin
          check("extra_instr", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("stream_instr", {28'd0, cur}, {28'd0, e});
        end
      end
      last_out = cur;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_redirect(input logic [15:0] target, input logic with_stall);
    redirect    = 1'b1;
    redirect_pc = target;
    stall       = with_stall;
    @(posedge clk);
    build(target);
    @(negedge clk);
    redirect = 1'b0;
    stall    = 1'b0;
  endtask

  task automatic check_first_instr(input string tag);
    check({tag, "_valid"}, {63'd0, valid_o}, 64'd1);
    check({tag, "_opcode"}, {60'd0, opcode_o}, 64'd6);
    check({tag, "_regD"}, {61'd0, regD_o}, 64'd1);
    check({tag, "_reg1"}, {61'd0, reg1_o}, 64'd2);
    check({tag, "_imm"}, {61'd0, imm_o}, 64'd3);
    check({tag, "_reg2"}, {61'd0, reg2_o}, 64'd0);
    check({tag, "_immFlag"}, {63'd0, immFlag_o}, 64'd1);
  endtask

  initial begin
    logic [15:0] w;
    n_pass = 0; n_total = 0; chk_en = 1'b0;
    edge_stall = 1'b0; edge_redirect = 1'b0; last_out = '0;
    for (int i = 0; i < 65536; i++) begin
      w = 16'($urandom);
      if (w[15:14] == 2'b11) w[15] = 1'b0;
      mem[i] = w;
    end
    mem[16'h0010] = 16'h1A53;
    mem[16'h0020] = 16'hC000; mem[16'h0021] = 16'hBEEF;
    mem[16'h0024] = 16'hD2C9; mem[16'h0025] = 16'h5678;
    mem[16'h0030] = 16'hF00F; mem[16'h0031] = 16'hAAAA;
    mem[16'h0100] = 16'h2A8E;
    mem[16'hFFFF] = 16'hE123; mem[16'h0000] = 16'h1234; mem[16'h0001] = 16'h4C00;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset_addr", {48'd0, imem_addr}, {48'd0, RPC});
    check("reset_valid", {63'd0, valid_o}, 64'd0);
    check("reset_fields", {29'd0, format_o, opcode_o, immFlag_o, regD_o, reg1_o, reg2_o, imm_o, jmpLoc_o}, 64'd0);

    build(RPC);
    chk_en = 1'b1;
    rst = 1'b0;
    step();
    check("first_edge_invalid", {63'd0, valid_o}, 64'd0);
    step();
    check_first_instr("first_instr");

    // Sequential run up to the jump at 0x20.
    repeat (15) step();
    step();
    check("jump_gap_valid", {63'd0, valid_o}, 64'd0);
    check("jump_next_fetch", {48'd0, imem_addr}, 64'h22);
    step();
    check("jump_valid", {63'd0, valid_o}, 64'd1);
    check("jump_format", {62'd0, format_o}, 64'd3);
    check("jump_loc", {48'd0, jmpLoc_o}, 64'hBEEF);

    // Stall three cycles in DECODE.
    stall = 1'b1;
    #1 held_addr = imem_addr;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_decode_addr", {48'd0, imem_addr}, {48'd0, held_addr});
    end
    stall = 1'b0;

    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (!valid_o) found = 1'b1;
    end
    check("reach_ext_state", {63'd0, found}, 64'd1);

    // Stall three cycles in EXT.
    stall = 1'b1;
    #1 held_addr = imem_addr;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_ext_addr", {48'd0, imem_addr}, {48'd0, held_addr});
      check("stall_ext_valid", {63'd0, valid_o}, 64'd0);
    end
    stall = 1'b0;
    step();
    check("ext_resume_valid", {63'd0, valid_o}, 64'd1);
    check("ext_resume_loc", {48'd0, jmpLoc_o}, 64'h5678);

    // Redirect (with stall) while a jump is half collected.
    do_redirect(16'h0030, 1'b0);
    step();
    check("pre_redirect_ext", {63'd0, valid_o}, 64'd0);
    do_redirect(16'h0100, 1'b1);
    check("redirect_ext_valid", {63'd0, valid_o}, 64'd0);
    step();
    check("redirect_target_valid", {63'd0, valid_o}, 64'd1);
    check("redirect_target_opcode", {60'd0, opcode_o}, 64'd10);
    check("redirect_target_imm", {61'd0, imm_o}, 64'd6);
    check("redirect_target_jmploc", {48'd0, jmpLoc_o}, 64'd0);
    repeat (3) step();

    // Jump whose extension word wraps to 0x0000.
    do_redirect(16'hFFFF, 1'b0);
    step();
    check("wrap_ext_valid", {63'd0, valid_o}, 64'd0);
    check("wrap_fetch_addr", {48'd0, imem_addr}, 64'h0001);
    step();
    check("wrap_jump_valid", {63'd0, valid_o}, 64'd1);
    check("wrap_jump_loc", {48'd0, jmpLoc_o}, 64'h1234);
    check("wrap_jump_format", {62'd0, format_o}, 64'd3);
    step();
    check("wrap_next_opcode", {60'd0, opcode_o}, 64'd3);
    repeat (4) step();

    // Asynchronous reset pulse between edges.
    @(posedge clk);
    #2 rst = 1'b1;
    build(RPC);
    #1;
    check("async_rst_valid", {63'd0, valid_o}, 64'd0);
    check("async_rst_fields", {29'd0, format_o, opcode_o, immFlag_o, regD_o, reg1_o, reg2_o, imm_o, jmpLoc_o}, 64'd0);
    check("async_rst_addr", {48'd0, imem_addr}, {48'd0, RPC});
    #1 rst = 1'b0;
    @(negedge clk);
    step();
    check("restart_first_edge", {63'd0, valid_o}, 64'd0);
    step();
    check_first_instr("restart_instr");
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
